line_draw_engine: RTL

- Bresenham line rasteriser fed by the HPS-driven PIO coordinate registers: start_x, start_y, end_x, end_y, colour and a go strobe.
- Emits one pixel write per accepted handshake toward the SRAM video-memory writer.
- Sits between the PIO output ports and the SRAM pixel master; one line in flight at a time.

---
 rtl/line_draw_engine.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/line_draw_engine.sv
// Bresenham line rasteriser: latches a line on start and emits one pixel per ready/valid handshake.
// Optional screen clipping is enabled by defining LINE_DRAW_CLIP_EN.
module line_draw_engine #(
  parameter int unsigned X_W      = 10,
  parameter int unsigned Y_W      = 9,
  parameter int unsigned COLOR_W  = 8,
  parameter int unsigned SCREEN_W = 640,
  parameter int unsigned SCREEN_H = 480
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [X_W-1:0]     start_x,
  input  logic [Y_W-1:0]     start_y,
  input  logic [X_W-1:0]     end_x,
  input  logic [Y_W-1:0]     end_y,
  input  logic [COLOR_W-1:0] color,
  output logic               busy,
  output logic               done,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic [X_W-1:0]     pix_x,
  output logic [Y_W-1:0]     pix_y,
  output logic [COLOR_W-1:0] pix_color
);

  localparam int unsigned CW = (X_W > Y_W) ? X_W : Y_W;
  localparam int unsigned EW = CW + 2;

  // The screen must be addressable by the coordinate ports.
  if (SCREEN_W > 2**X_W || SCREEN_H > 2**Y_W) begin : g_bad_screen
    $error("line_draw_engine: screen size exceeds coordinate width");
  end

  typedef enum logic [1:0] {IDLE, INIT, DRAW, DONE} state_t;

  state_t               state;
  logic [CW-1:0]        lx0, ly0, lx1, ly1;
  logic [COLOR_W-1:0]   color_q;
  logic [CW-1:0]        x_q, y_q, xe_q, dx_q, dy_q;
  logic signed [EW-1:0] err_q;
  logic                 yneg_q, steep_q;

  // Octant normalisation of the latched endpoints.
  logic [CW-1:0] adx, ady, sx0, sy0, sx1, sy1, ix0, iy0, ix1, iy1, idx, idy;
  logic          steep_c, swap_c, yneg_c;

  always_comb begin
    adx     = (lx1 >= lx0) ? lx1 - lx0 : lx0 - lx1;
    ady     = (ly1 >= ly0) ? ly1 - ly0 : ly0 - ly1;
    steep_c = ady > adx;
    sx0     = steep_c ? ly0 : lx0;
    sy0     = steep_c ? lx0 : ly0;
    sx1     = steep_c ? ly1 : lx1;
    sy1     = steep_c ? lx1 : ly1;
    swap_c  = sx0 > sx1;
    ix0     = swap_c ? sx1 : sx0;
    iy0     = swap_c ? sy1 : sy0;
    ix1     = swap_c ? sx0 : sx1;
    iy1     = swap_c ? sy0 : sy1;
    idx     = ix1 - ix0;
    idy     = (iy1 >= iy0) ? iy1 - iy0 : iy0 - iy1;
    yneg_c  = !(iy0 < iy1);
  end

  // One Bresenham step from the current point.
  logic [CW-1:0]        nx, ny;
  logic signed [EW-1:0] err_dec, nerr;

  always_comb begin
    err_dec = err_q - $signed({2'b00, dy_q});
    nx      = x_q + CW'(1);
    ny      = y_q;
    nerr    = err_dec;
    if (err_dec[EW-1]) begin
      ny   = yneg_q ? y_q - CW'(1) : y_q + CW'(1);
      nerr = err_dec + $signed({2'b00, dx_q});
    end
  end

  // Screen coordinates of the point about to be presented.
  logic [CW-1:0] pt_a, pt_b, pt_sx, pt_sy;
  logic          pt_steep, pt_vis;

  always_comb begin
    pt_a     = (state == INIT) ? ix0 : nx;
    pt_b     = (state == INIT) ? iy0 : ny;
    pt_steep = (state == INIT) ? steep_c : steep_q;
    pt_sx    = pt_steep ? pt_b : pt_a;
    pt_sy    = pt_steep ? pt_a : pt_b;
`ifdef LINE_DRAW_CLIP_EN
    pt_vis   = (pt_sx < CW'(SCREEN_W)) && (pt_sy < CW'(SCREEN_H));
`else
    pt_vis   = 1'b1;
`endif
  end

  // A suppressed point (pix_valid low in DRAW) advances without a handshake.
  logic advance, last_pt;
  assign advance = (state == DRAW) && (!pix_valid || pix_ready);
  assign last_pt = (x_q == xe_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      pix_valid <= 1'b0;
      pix_x     <= '0;
      pix_y     <= '0;
      pix_color <= '0;
      lx0       <= '0;
      ly0       <= '0;
      lx1       <= '0;
      ly1       <= '0;
      color_q   <= '0;
      x_q       <= '0;
      y_q       <= '0;
      xe_q      <= '0;
      dx_q      <= '0;
      dy_q      <= '0;
      err_q     <= '0;
      yneg_q    <= 1'b0;
      steep_q   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            lx0     <= CW'(start_x);
            ly0     <= CW'(start_y);
            lx1     <= CW'(end_x);
            ly1     <= CW'(end_y);
            color_q <= color;
            busy    <= 1'b1;
            state   <= INIT;
          end
        end
        INIT: begin
          x_q       <= ix0;
          y_q       <= iy0;
          xe_q      <= ix1;
          dx_q      <= idx;
          dy_q      <= idy;
          err_q     <= $signed({2'b00, idx >> 1});
          yneg_q    <= yneg_c;
          steep_q   <= steep_c;
          pix_x     <= X_W'(pt_sx);
          pix_y     <= Y_W'(pt_sy);
          pix_color <= color_q;
          pix_valid <= pt_vis;
          state     <= DRAW;
        end
        DRAW: begin
          if (advance) begin
            if (last_pt) begin
              pix_valid <= 1'b0;
              done      <= 1'b1;
              busy      <= 1'b0;
              state     <= DONE;
            end else begin
              x_q       <= nx;
              y_q       <= ny;
              err_q     <= nerr;
              pix_x     <= X_W'(pt_sx);
              pix_y     <= Y_W'(pt_sy);
              pix_valid <= pt_vis;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
